// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the 4-point radix-2 DIT FFT sequencer.
//   fft_state_t   : sequencer FSM state encoding
//   N_POINTS      : FFT size (fixed at 4)
//   ADDR_W        : sample/result index width
//   OP_A/OP_B/OP_TW : butterfly operation table, indexed by op number
//   bitrev2       : 2-bit index bit reversal used for the load order
package fft_pkg;

    localparam int N_POINTS = 4;
    localparam int ADDR_W   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        OUTPUT = 3'd4
    } fft_state_t;

    // Butterfly table, element [k] is op k.
    // Stage 1: (0,1,W0) (2,3,W0); stage 2: (0,2,W0) (1,3,W1).
    localparam logic [3:0][ADDR_W-1:0] OP_A  = {2'd1, 2'd0, 2'd2, 2'd0};
    localparam logic [3:0][ADDR_W-1:0] OP_B  = {2'd3, 2'd2, 2'd3, 2'd1};
    localparam logic [3:0]             OP_TW = 4'b1000;

    function automatic logic [ADDR_W-1:0] bitrev2(input logic [ADDR_W-1:0] v);
        return {v[0], v[1]};
    endfunction

endpackage

// File: rtl/fft_sched.sv
// fft_sched: sequencing controller for the 4-point radix-2 DIT FFT core.
// Loads samples in bit-reversed order, issues the four butterfly ops over two
// stages with a start/done handshake, then steps the result read index.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ena             : global enable, low freezes all state and kills strobes
//   load_pulse      : input sample strobe from the I/O controller
//   output_pulse    : advance-to-next-result strobe
//   bfly_done       : butterfly unit has written back the current op
//   wr_en, wr_addr  : sample register file write (bit-reversed load count)
//   bfly_start      : one-cycle start strobe for the butterfly unit
//   bfly_a, bfly_b  : operand indices, tw_idx : twiddle select (1 = -j)
//   rd_addr         : result read index, out_valid : results readable
//   busy            : compute phase (ISSUE/WAIT)
//   frame_done      : one-cycle strobe in the first IDLE cycle after a frame
//   overrun         : sticky, load arrived while not accepting samples
//   timeout_err     : sticky, butterfly watchdog expired
//
// Butterfly handshake: bfly_start is high for exactly one cycle (ISSUE) with
// bfly_a/bfly_b/tw_idx already stable; they stay stable until the matching
// bfly_done, which is only honoured in WAIT (a done during ISSUE is dropped).
module fft_sched
    #(
        parameter int N_POINTS     = 4,
        parameter int ADDR_W       = 2,
        parameter int BFLY_TIMEOUT = 15
    )
    (
        input  logic              clk,
        input  logic              rst,
        input  logic              ena,
        input  logic              load_pulse,
        input  logic              output_pulse,
        input  logic              bfly_done,
        output logic              wr_en,
        output logic [ADDR_W-1:0] wr_addr,
        output logic              bfly_start,
        output logic [ADDR_W-1:0] bfly_a,
        output logic [ADDR_W-1:0] bfly_b,
        output logic              tw_idx,
        output logic [ADDR_W-1:0] rd_addr,
        output logic              out_valid,
        output logic              busy,
        output logic              frame_done,
        output logic              overrun,
        output logic              timeout_err
    );

    import fft_pkg::*;

    if (N_POINTS != 4) begin : g_bad_size
        $error("fft_sched supports N_POINTS == 4 only");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
    localparam int                WD_W     = (BFLY_TIMEOUT < 2) ? 1 : $clog2(BFLY_TIMEOUT + 1);
    localparam logic [WD_W:0]     WD_LIMIT = (WD_W + 1)'(BFLY_TIMEOUT);

    fft_state_t        state, state_next;
    logic [ADDR_W-1:0] ld_cnt, ld_next;
    logic [ADDR_W-1:0] op_cnt, op_next;
    logic [ADDR_W-1:0] out_cnt, out_next;
    logic [WD_W-1:0]   wd_cnt, wd_next;
    logic [WD_W:0]     wd_plus;
    logic              accept_load;
    logic              load_op;
    logic              set_ovr;
    logic              set_to;
    logic              fdone_next;
    logic              frame_done_q;

    assign wd_plus = {1'b0, wd_cnt} + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ld_cnt       <= '0;
            op_cnt       <= '0;
            out_cnt      <= '0;
            wd_cnt       <= '0;
            bfly_a       <= '0;
            bfly_b       <= '0;
            tw_idx       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (ena) begin
            state        <= state_next;
            ld_cnt       <= ld_next;
            op_cnt       <= op_next;
            out_cnt      <= out_next;
            wd_cnt       <= wd_next;
            frame_done_q <= fdone_next;
            // Operands are captured on entry to ISSUE so they are valid
            // alongside bfly_start and hold through WAIT.
            if (load_op) begin
                bfly_a <= OP_A[op_next];
                bfly_b <= OP_B[op_next];
                tw_idx <= OP_TW[op_next];
            end
            if (set_ovr) overrun     <= 1'b1;
            if (set_to)  timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        ld_next     = ld_cnt;
        op_next     = op_cnt;
        out_next    = out_cnt;
        wd_next     = wd_cnt;
        accept_load = 1'b0;
        load_op     = 1'b0;
        set_ovr     = 1'b0;
        set_to      = 1'b0;
        fdone_next  = 1'b0;

        case (state)
            IDLE, LOAD: begin
                if (load_pulse) begin
                    accept_load = 1'b1;
                    ld_next     = ld_cnt + 1'b1;
                    state_next  = LOAD;
                    if (ld_cnt == LAST_IDX) begin
                        ld_next    = '0;
                        op_next    = '0;
                        load_op    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                set_ovr    = load_pulse;
                wd_next    = '0;
                state_next = WAIT;
            end
            WAIT: begin
                set_ovr = load_pulse;
                if (bfly_done) begin
                    if (op_cnt == LAST_IDX) begin
                        op_next    = '0;
                        out_next   = '0;
                        state_next = OUTPUT;
                    end else begin
                        op_next    = op_cnt + 1'b1;
                        load_op    = 1'b1;
                        state_next = ISSUE;
                    end
                end else if ((BFLY_TIMEOUT > 0) && (wd_plus == WD_LIMIT)) begin
                    // Abort the frame; counters restart from zero.
                    set_to     = 1'b1;
                    ld_next    = '0;
                    op_next    = '0;
                    out_next   = '0;
                    wd_next    = '0;
                    state_next = IDLE;
                end else begin
                    wd_next = wd_plus[WD_W-1:0];
                end
            end
            OUTPUT: begin
                set_ovr = load_pulse;
                if (output_pulse) begin
                    if (out_cnt == LAST_IDX) begin
                        out_next   = '0;
                        fdone_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        out_next = out_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // wr_en is a zero-latency decode of the load strobe; rst is folded in so
    // every output is low while reset is held.
    assign wr_en      = accept_load & ena & ~rst;
    assign wr_addr    = bitrev2(ld_cnt);
    assign bfly_start = (state == ISSUE) & ena;
    assign busy       = (state == ISSUE) | (state == WAIT);
    assign out_valid  = (state == OUTPUT);
    assign rd_addr    = out_cnt;
    assign frame_done = frame_done_q & ena;

endmodule

// File: tb/tb_fft_sched.sv
module tb_fft_sched;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       load_pulse;
    logic       output_pulse;
    logic       bfly_done;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic       bfly_start;
    logic [1:0] bfly_a;
    logic [1:0] bfly_b;
    logic       tw_idx;
    logic [1:0] rd_addr;
    logic       out_valid;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;
    int start_seen = 0;
    int ld_model   = 0;

    // Expected write addresses and expected {a,b,tw} per issued op.
    logic [1:0] wr_exp_q[$];
    logic [4:0] op_exp_q[$];

    logic [1:0] addr_tbl [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [4:0] op_tbl   [4] = '{5'b00010, 5'b10110, 5'b00100, 5'b01111};

    fft_sched #(.N_POINTS(4), .ADDR_W(2), .BFLY_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .load_pulse(load_pulse), .output_pulse(output_pulse), .bfly_done(bfly_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .bfly_start(bfly_start),
        .bfly_a(bfly_a), .bfly_b(bfly_b), .tw_idx(tw_idx),
        .rd_addr(rd_addr), .out_valid(out_valid), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (wr_en) begin
            checks++;
            if (wr_exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: wr_en=1 wr_addr=%0d, no write expected", wr_addr);
            end else begin
                logic [1:0] e;
                e = wr_exp_q.pop_front();
                if (wr_addr !== e) begin
                    failures++;
                    $display("FAIL wr_addr: got %0d expected %0d", wr_addr, e);
                end
            end
        end
        if (bfly_start) begin
            start_seen++;
            checks++;
            if (op_exp_q.size() == 0) begin
                failures++;
                $display("FAIL op_unexpected: bfly_start with a=%0d b=%0d tw=%0d", bfly_a, bfly_b, tw_idx);
            end else begin
                logic [4:0] e;
                e = op_exp_q.pop_front();
                if ({bfly_a, bfly_b, tw_idx} !== e) begin
                    failures++;
                    $display("FAIL op_operands: got a=%0d b=%0d tw=%0d expected a=%0d b=%0d tw=%0d",
                             bfly_a, bfly_b, tw_idx, e[4:3], e[2:1], e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        wr_exp_q.push_back(addr_tbl[ld_model]);
        ld_model++;
        if (ld_model == 4) begin
            ld_model = 0;
            for (int k = 0; k < 4; k++) op_exp_q.push_back(op_tbl[k]);
        end
        load_pulse = 1'b1;
        tick();
        load_pulse = 1'b0;
    endtask

    task automatic load_frame();
        for (int i = 0; i < 4; i++) begin
            do_load();
            if (i < 3) tick();
        end
    endtask

    // Returns at the negedge where bfly_start is seen.
    task automatic wait_start(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bfly_start) begin
                ok = 1'b1;
                waited = i;
                break;
            end
        end
    endtask

    // Runs n ops, returning bfly_done 3 cycles after each start.
    task automatic run_ops(input int n, output int first_wait);
        bit ok;
        int w;
        first_wait = -1;
        for (int k = 0; k < n; k++) begin
            wait_start(ok, w);
            if (k == 0) first_wait = w;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL start_timeout: op %0d bfly_start not seen, got 0 expected 1", k);
            end
            tick();
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_wait: got %0b expected 1", busy);
            end
            tick();
            tick();
            bfly_done = 1'b1;
            tick();
            bfly_done = 1'b0;
        end
    endtask

    task automatic do_outputs(input bit load_on_last);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || rd_addr !== 2'(k)) begin
                failures++;
                $display("FAIL out_step: out_valid=%0b rd_addr=%0d expected 1/%0d", out_valid, rd_addr, k);
            end
            output_pulse = 1'b1;
            if (k == 3 && load_on_last) load_pulse = 1'b1;
            tick();
            output_pulse = 1'b0;
            load_pulse   = 1'b0;
        end
        checks++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_pulse: frame_done=%0b out_valid=%0b busy=%0b expected 1/0/0",
                     frame_done, out_valid, busy);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_width: got %0b expected 0", frame_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int fw;
        bit ok;
        int w;
        checks++;
        if ({wr_en, bfly_start, busy, out_valid, frame_done, overrun, timeout_err} !== 7'b0 ||
            wr_addr !== 2'd0 || rd_addr !== 2'd0 || {bfly_a, bfly_b, tw_idx} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero during reset");
        end
        rst = 1'b0;
        tick();
        // Drive into WAIT of op 2, then reset mid-frame.
        load_frame();
        run_ops(2, fw);
        wait_start(ok, w);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_reach_op2: got 0 expected 1");
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bfly_start !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0 ||
            wr_addr !== 2'd0 || rd_addr !== 2'd0 || {bfly_a, bfly_b, tw_idx} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_wait: busy=%0b start=%0b out_valid=%0b overrun=%0b wr_addr=%0d expected all 0",
                     busy, bfly_start, out_valid, overrun, wr_addr);
        end
        tick();
        rst = 1'b0;
        op_exp_q.delete();
        wr_exp_q.delete();
        ld_model = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%0b out_valid=%0b expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_frame();
        int fw;
        load_frame();
        run_ops(4, fw);
        checks++;
        if (fw !== 0) begin
            failures++;
            $display("FAIL first_start_latency: waited %0d expected 0", fw);
        end
        checks++;
        if (out_valid !== 1'b1 || rd_addr !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL out_valid_rise: out_valid=%0b rd_addr=%0d busy=%0b expected 1/0/0",
                     out_valid, rd_addr, busy);
        end
        do_outputs(1'b0);
        // Re-armed with no extra output_pulse: first load lands at address 0.
        do_load();
        tick();
    endtask

    task automatic test_overrun();
        bit ok;
        int w;
        int fw;
        for (int i = 1; i < 4; i++) begin
            do_load();
            if (i < 3) tick();
        end
        wait_start(ok, w);
        tick();
        load_pulse = 1'b1;        // during WAIT of op 0
        tick();
        load_pulse = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_wait: got %0b expected 1", overrun);
        end
        bfly_done = 1'b1;
        tick();
        bfly_done = 1'b0;
        run_ops(3, fw);
        load_pulse = 1'b1;        // during OUTPUT
        tick();
        load_pulse = 1'b0;
        do_outputs(1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %0b expected 1", overrun);
        end
    endtask

    task automatic test_ena();
        bit ok;
        int w;
        int fw;
        int seen0;
        load_frame();
        wait_start(ok, w);
        tick();                   // first WAIT cycle, enabled
        tick();
        seen0 = start_seen;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bfly_done = (i == 2);
            tick();
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL ena_hold_busy: got %0b expected 1", busy);
            end
        end
        bfly_done = 1'b0;
        ena = 1'b1;
        // One enabled WAIT cycle so far; the watchdog needs 13 more before
        // its final cycle.
        for (int i = 0; i < 13; i++) begin
            tick();
        end
        checks++;
        if (busy !== 1'b1 || start_seen != seen0) begin
            failures++;
            $display("FAIL ena_resume_wait: busy=%0b starts=%0d expected 1/%0d", busy, start_seen, seen0);
        end
        bfly_done = 1'b1;
        tick();
        bfly_done = 1'b0;
        run_ops(3, fw);
        checks++;
        if (timeout_err !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ena_resume_done: timeout_err=%0b out_valid=%0b expected 0/1", timeout_err, out_valid);
        end
        do_outputs(1'b0);
    endtask

    task automatic test_timeout();
        bit ok;
        int w;
        load_frame();
        wait_start(ok, w);
        tick();
        for (int i = 1; i <= 15; i++) begin
            checks++;
            if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_early: cycle %0d busy=%0b timeout_err=%0b expected 1/0", i, busy, timeout_err);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: busy=%0b timeout_err=%0b expected 0/1", busy, timeout_err);
        end
        op_exp_q.delete();
        // After abort the load counter restarts at zero.
        do_load();
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got %0b expected 1", timeout_err);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst          = 1'b1;
        ena          = 1'b1;
        load_pulse   = 1'b0;
        output_pulse = 1'b0;
        bfly_done    = 1'b0;
        tick();
        tick();
        test_reset();
        test_frame();
        test_overrun();
        test_ena();
        test_timeout();
        repeat (3) tick();
        checks++;
        if (wr_exp_q.size() != 0 || op_exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: wr left %0d op left %0d expected 0/0", wr_exp_q.size(), op_exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_sched.md
Name: fft_sched

Overview:
Sequencing controller for the 4-point radix-2 DIT FFT core. It consumes the one-cycle load/output strobes from the I/O controller and does four things: writes samples into the sample register file in bit-reversed order, issues the four butterfly operations over two stages with a start/done handshake, then steps the output read index. It sits between the I/O controller, the sample register file and the butterfly unit.

Parameters:
N_POINTS, 4, FFT size; fixed at 4, any other value is a compile-time error.
ADDR_W, 2, width of sample/result index (log2 N_POINTS).
BFLY_TIMEOUT, 15, max cycles waiting for bfly_done before abort; 0 disables the watchdog.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ena  in  1  global enable; low freezes all state
load_pulse  in  1  one-cycle strobe: input sample present on data bus
output_pulse  in  1  one-cycle strobe: advance to next result
bfly_done  in  1  one-cycle strobe from butterfly unit: current op written back
wr_en  out  1  write sample register file
wr_addr  out  ADDR_W  sample write index (bit-reversed load count)
bfly_start  out  1  one-cycle strobe: begin butterfly op
bfly_a  out  ADDR_W  butterfly upper operand index
bfly_b  out  ADDR_W  butterfly lower operand index
tw_idx  out  1  twiddle select (0 = W0, 1 = W1 = -j)
rd_addr  out  ADDR_W  result read index
out_valid  out  1  results readable
busy  out  1  compute phase in progress
frame_done  out  1  one-cycle strobe after last result consumed
overrun  out  1  sticky: load_pulse arrived while not accepting samples
timeout_err  out  1  sticky: watchdog expired

Behaviour:
- Reset (async, immediate, also mid-frame):
  - State goes to IDLE.
  - All counters go to 0.
  - Every output goes to 0.
- ena=0: FSM, counters and watchdog hold. All inputs are ignored. Strobe outputs (wr_en, bfly_start, frame_done) are forced 0.
- FSM states: IDLE, LOAD, ISSUE, WAIT, OUTPUT.
- IDLE/LOAD (sample loading):
  - wr_en = load_pulse & ena, combinational, zero latency.
  - wr_addr = bitrev(ld_cnt): load order 0,1,2,3 maps to addresses 0,2,1,3.
  - ld_cnt increments on each accepted load.
  - IDLE moves to LOAD on the first load.
  - The 4th load moves to ISSUE with op_cnt=0.
- Butterfly op table (op: a,b,tw):
  - op 0: 0,1,0
  - op 1: 2,3,0
  - op 2: 0,2,0
  - op 3: 1,3,1
  - bfly_a, bfly_b and tw_idx are registered from op_cnt and stay stable throughout ISSUE and WAIT.
- ISSUE: bfly_start=1 for exactly one cycle, then WAIT. A bfly_done in the ISSUE cycle is ignored.
- WAIT:
  - On bfly_done with op_cnt<3: op_cnt++ and go to ISSUE. This gives minimum 2 cycles per op.
  - On bfly_done with op_cnt=3: go to OUTPUT with out_cnt=0.
- busy=1 in ISSUE and WAIT.
- Watchdog: wd_cnt resets on each ISSUE. If BFLY_TIMEOUT>0 and wd_cnt reaches BFLY_TIMEOUT in WAIT without bfly_done, set timeout_err and go to IDLE with all counters cleared.
- OUTPUT:
  - out_valid=1 and rd_addr=out_cnt (natural order).
  - Each output_pulse increments out_cnt.
  - output_pulse at out_cnt=3 goes to IDLE. frame_done is a registered pulse high for the first IDLE cycle.
  - No further output_pulse is needed to re-arm.
- load_pulse in ISSUE, WAIT or OUTPUT (including the same cycle as the final output_pulse) is ignored, sets overrun, and produces no wr_en.
- output_pulse outside OUTPUT is ignored.
- load_pulse and output_pulse in the same cycle during LOAD: the load is taken, the output pulse is ignored.
- overrun and timeout_err clear only on rst.

Decomposition:
- Shared package fft_pkg holds:
  - state enum fft_state_t;
  - N_POINTS and ADDR_W constants;
  - the op table as constant arrays OP_A, OP_B, OP_TW;
  - function bitrev2.
- No sub-module needed. The watchdog counter stays inline.

Test Plan:
- Reset mid-WAIT (op 2) -> next cycle: IDLE, busy=0, bfly_start=0, counters 0, overrun=0.
- Four load_pulses on cycles 2,4,6,8 -> wr_en high same cycles with wr_addr 0,2,1,3; bfly_start on cycle 9 with a=0, b=1, tw=0.
- bfly_done returned 3 cycles after each start -> ops issued in order (0,1,0),(2,3,0),(0,2,0),(1,3,1); out_valid rises the cycle after the 4th done, rd_addr=0.
- Four output_pulses -> rd_addr 0,1,2,3 then IDLE; frame_done high exactly 1 cycle; a new load is accepted with wr_addr=0.
- load_pulse during WAIT and during OUTPUT -> no wr_en, overrun=1 and stays 1 after the frame completes.
- bfly_done withheld with BFLY_TIMEOUT=15 -> timeout_err=1 and IDLE 15 cycles after entering WAIT.
- ena held low 5 cycles in WAIT with bfly_done pulsed -> state, op_cnt and wd_cnt unchanged; resumes correctly when ena returns high.
